pipe_hazard_ctrl: RTL and testbench

Pipeline sequencer for the 4-stage RISC core (IF, DOF, EX, WB). It keeps a 2-entry scoreboard of in-flight register writes and detects RAW hazards on the instruction in DOF. It generates the hold, bubble and flush controls for the pipeline registers, including flushes on taken branches and freezes while data memory is busy. It also keeps saturating stall and flush counters for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 4-stage core: RAW scoreboard,
// hold/bubble/flush generation and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter bit RF_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dof_valid,
  input  logic [4:0]       dof_da,
  input  logic [4:0]       dof_aa,
  input  logic [4:0]       dof_ba,
  input  logic             dof_rw,
  input  logic             dof_ma,
  input  logic             dof_mb,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ir_hold,
  output logic             ex_bubble,
  output logic             ex_hold,
  output logic             if_flush,
  output logic [1:0]       pipe_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    C_RUN    = 2'd0,
    C_STALL  = 2'd1,
    C_FLUSH  = 2'd2,
    C_FREEZE = 2'd3
  } cls_t;

  typedef struct packed {
    logic       v;
    logic [4:0] da;
  } sb_t;

  sb_t  sb_ex;
  sb_t  sb_wb;
  sb_t  sb_new;
  cls_t cls;
  logic hz_ex;
  logic hz_wb;
  logic hazard;

  function automatic logic hit(
    input sb_t        e,
    input logic       ma,
    input logic       mb,
    input logic [4:0] aa,
    input logic [4:0] ba
  );
    logic rd;
    rd = (!ma && aa == e.da) || (!mb && ba == e.da);
    return rd && e.v && (e.da != 5'd0);
  endfunction

  // Scoreboard is treated as empty while rst is high.
  always_comb begin
    hz_ex  = hit(sb_ex, dof_ma, dof_mb, dof_aa, dof_ba);
    hz_wb  = hit(sb_wb, dof_ma, dof_mb, dof_aa, dof_ba);
    hazard = !rst && dof_valid &&
             (hz_ex || (!RF_BYPASS && hz_wb));
  end

  always_comb begin
    cls = C_RUN;
    if (mem_busy)
      cls = C_FREEZE;
    else if (ex_br_taken)
      cls = C_FLUSH;
    else if (hazard)
      cls = C_STALL;
  end

  always_comb begin
    pc_hold   = 1'b0;
    ir_hold   = 1'b0;
    ex_bubble = 1'b0;
    ex_hold   = 1'b0;
    if_flush  = 1'b0;
    unique case (cls)
      C_STALL: begin
        pc_hold   = 1'b1;
        ir_hold   = 1'b1;
        ex_bubble = 1'b1;
      end
      C_FLUSH: begin
        if_flush  = 1'b1;
        ex_bubble = 1'b1;
      end
      C_FREEZE: begin
        pc_hold = 1'b1;
        ir_hold = 1'b1;
        ex_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sb_new = '0;
    if (cls == C_RUN) begin
      sb_new.v  = dof_valid && dof_rw && (dof_da != 5'd0);
      sb_new.da = dof_da;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex <= '0;
      sb_wb <= '0;
    end else if (cls != C_FREEZE) begin
      sb_wb <= sb_ex;
      sb_ex <= sb_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_state <= 2'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      pipe_state <= cls;
      if (cls == C_STALL && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (cls == C_FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default, write-first RF
// and narrow-counter instances driven from shared stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dof_valid;
  logic [4:0] dof_da;
  logic [4:0] dof_aa;
  logic [4:0] dof_ba;
  logic       dof_rw;
  logic       dof_ma;
  logic       dof_mb;
  logic       ex_br_taken;
  logic       mem_busy;

  logic        a_pc, a_ir, a_bub, a_exh, a_fl;
  logic [1:0]  a_ps;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ir, b_bub, b_exh, b_fl;
  logic [1:0]  b_ps;
  logic [15:0] b_sc, b_fc;
  logic        c_pc, c_ir, c_bub, c_exh, c_fl;
  logic [1:0]  c_ps;
  logic [2:0]  c_sc, c_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RF_BYPASS(1'b0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .dof_valid(dof_valid),
    .dof_da(dof_da), .dof_aa(dof_aa), .dof_ba(dof_ba),
    .dof_rw(dof_rw), .dof_ma(dof_ma), .dof_mb(dof_mb),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_hold(a_pc), .ir_hold(a_ir), .ex_bubble(a_bub),
    .ex_hold(a_exh), .if_flush(a_fl), .pipe_state(a_ps),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipe_hazard_ctrl #(.RF_BYPASS(1'b1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .dof_valid(dof_valid),
    .dof_da(dof_da), .dof_aa(dof_aa), .dof_ba(dof_ba),
    .dof_rw(dof_rw), .dof_ma(dof_ma), .dof_mb(dof_mb),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_hold(b_pc), .ir_hold(b_ir), .ex_bubble(b_bub),
    .ex_hold(b_exh), .if_flush(b_fl), .pipe_state(b_ps),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  pipe_hazard_ctrl #(.RF_BYPASS(1'b0), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .dof_valid(dof_valid),
    .dof_da(dof_da), .dof_aa(dof_aa), .dof_ba(dof_ba),
    .dof_rw(dof_rw), .dof_ma(dof_ma), .dof_mb(dof_mb),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_hold(c_pc), .ir_hold(c_ir), .ex_bubble(c_bub),
    .ex_hold(c_exh), .if_flush(c_fl), .pipe_state(c_ps),
    .stall_cnt(c_sc), .flush_cnt(c_fc)
  );

  // {pc_hold, ir_hold, ex_bubble, ex_hold, if_flush}
  localparam logic [4:0] O_RUN = 5'b00000;
  localparam logic [4:0] O_STL = 5'b11100;
  localparam logic [4:0] O_FLS = 5'b00101;
  localparam logic [4:0] O_FRZ = 5'b11010;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  da;
    logic [4:0]  aa;
    logic [4:0]  ba;
    logic        rw;
    logic        ma;
    logic        mb;
    logic        br;
    logic        busy;
    logic [4:0]  eo;
    logic [1:0]  eps;
    logic [15:0] esc;
    logic [15:0] efc;
  } vec_t;

  function automatic vec_t mk(
    input logic rs, input logic vl,
    input logic [4:0] da, input logic [4:0] aa,
    input logic [4:0] ba, input logic rw,
    input logic ma, input logic mb,
    input logic br, input logic busy,
    input logic [4:0] eo, input logic [1:0] eps,
    input logic [15:0] esc, input logic [15:0] efc
  );
    vec_t v;
    v.rst = rs;   v.valid = vl;
    v.da = da;    v.aa = aa;    v.ba = ba;
    v.rw = rw;    v.ma = ma;    v.mb = mb;
    v.br = br;    v.busy = busy;
    v.eo = eo;    v.eps = eps;
    v.esc = esc;  v.efc = efc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst         = v.rst;
    dof_valid   = v.valid;
    dof_da      = v.da;
    dof_aa      = v.aa;
    dof_ba      = v.ba;
    dof_rw      = v.rw;
    dof_ma      = v.ma;
    dof_mb      = v.mb;
    ex_br_taken = v.br;
    mem_busy    = v.busy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t tv[26];
  vec_t rs_v, prod, cons;
  int   n;

  initial begin
    rst = 1'b1; dof_valid = 1'b0; dof_da = '0;
    dof_aa = '0; dof_ba = '0; dof_rw = 1'b0;
    dof_ma = 1'b0; dof_mb = 1'b0;
    ex_br_taken = 1'b0; mem_busy = 1'b0;

    //           rs vl da  aa  ba rw ma mb br bz  out   ps sc fc
    tv[0]  = mk(1, 0, 0,  0,  0, 0, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    tv[1]  = mk(0, 1, 3,  1,  2, 1, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    tv[2]  = mk(0, 1, 4,  3,  5, 1, 0, 0, 0, 0, O_STL, 1, 1, 0);
    tv[3]  = mk(0, 1, 4,  3,  5, 1, 0, 0, 0, 0, O_STL, 1, 2, 0);
    tv[4]  = mk(0, 1, 4,  3,  5, 1, 0, 0, 0, 0, O_RUN, 0, 2, 0);
    tv[5]  = mk(0, 1, 0,  6,  7, 1, 0, 0, 0, 0, O_RUN, 0, 2, 0);
    tv[6]  = mk(0, 1, 8,  0,  0, 1, 0, 0, 0, 0, O_RUN, 0, 2, 0);
    tv[7]  = mk(0, 1, 10, 9,  8, 1, 0, 1, 0, 0, O_RUN, 0, 2, 0);
    tv[8]  = mk(0, 1, 12, 10, 11, 1, 1, 0, 0, 0, O_RUN, 0, 2, 0);
    tv[9]  = mk(0, 1, 13, 12, 0, 1, 0, 0, 1, 0, O_FLS, 2, 2, 1);
    tv[10] = mk(0, 1, 0,  13, 0, 0, 0, 0, 0, 0, O_RUN, 0, 2, 1);
    tv[11] = mk(0, 1, 5,  0,  0, 1, 0, 0, 0, 0, O_RUN, 0, 2, 1);
    tv[12] = mk(0, 1, 6,  5,  0, 0, 0, 0, 1, 1, O_FRZ, 3, 2, 1);
    tv[13] = mk(0, 1, 6,  5,  0, 0, 0, 0, 1, 1, O_FRZ, 3, 2, 1);
    tv[14] = mk(0, 1, 6,  5,  0, 0, 0, 0, 1, 1, O_FRZ, 3, 2, 1);
    tv[15] = mk(0, 1, 6,  5,  0, 0, 0, 0, 1, 0, O_FLS, 2, 2, 2);
    tv[16] = mk(0, 1, 6,  0,  5, 0, 0, 0, 0, 0, O_STL, 1, 3, 2);
    tv[17] = mk(0, 1, 6,  0,  5, 0, 0, 0, 0, 0, O_RUN, 0, 3, 2);
    tv[18] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1, O_FRZ, 3, 3, 2);
    tv[19] = mk(0, 1, 7,  0,  0, 1, 0, 0, 0, 0, O_RUN, 0, 3, 2);
    tv[20] = mk(0, 0, 0,  7,  0, 0, 0, 0, 0, 0, O_RUN, 0, 3, 2);
    tv[21] = mk(0, 1, 7,  0,  0, 1, 0, 0, 0, 0, O_RUN, 0, 3, 2);
    tv[22] = mk(0, 1, 9,  7,  0, 0, 0, 0, 0, 0, O_STL, 1, 4, 2);
    tv[23] = mk(1, 1, 9,  7,  0, 0, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    tv[24] = mk(0, 1, 9,  7,  0, 0, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    tv[25] = mk(0, 0, 0,  0,  0, 0, 0, 0, 0, 0, O_RUN, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(tv[i]);
      chk("outs", i, {a_pc, a_ir, a_bub, a_exh, a_fl}, tv[i].eo);
      tick;
      chk("pipe_state", i, a_ps, tv[i].eps);
      chk("stall_cnt", i, a_sc, tv[i].esc);
      chk("flush_cnt", i, a_fc, tv[i].efc);
    end

    // Write-first register file: dependent pair stalls once.
    rs_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    prod = mk(0, 1, 3, 1, 2, 1, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    cons = mk(0, 1, 4, 3, 5, 1, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    drive(rs_v); tick;
    chk("byp_rst_sc", 0, b_sc, 0);
    drive(prod); tick;
    drive(cons);
    chk("byp_outs", 0, {b_pc, b_ir, b_bub, b_exh, b_fl}, O_STL);
    tick;
    chk("byp_ps", 0, b_ps, 1);
    chk("byp_sc", 0, b_sc, 1);
    drive(cons);
    chk("byp_outs", 1, {b_pc, b_ir, b_bub, b_exh, b_fl}, O_RUN);
    tick;
    chk("byp_ps", 1, b_ps, 0);
    chk("byp_sc", 1, b_sc, 1);

    // 3-bit counter: ten stall cycles must stop at 7.
    prod = mk(0, 1, 3, 0, 0, 1, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    cons = mk(0, 1, 9, 3, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0, 0);
    drive(rs_v); tick;
    chk("sat_rst", 0, c_sc, 0);
    n = 0;
    for (int p = 0; p < 5; p++) begin
      drive(prod); tick;
      for (int s = 0; s < 2; s++) begin
        drive(cons);
        chk("sat_outs", n, {c_pc, c_ir, c_bub, c_exh, c_fl}, O_STL);
        tick;
        n++;
        chk("sat_cnt", n, c_sc, (n > 7) ? 7 : n);
      end
      drive(cons);
      chk("sat_run", p, {c_pc, c_ir, c_bub, c_exh, c_fl}, O_RUN);
      tick;
    end
    chk("sat_final", 0, c_sc, 7);
    chk("sat_fc", 0, c_fc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
